// File: rtl/seg7_capture_decoder.sv
// ---------------------------------------------------------------------------
// seg7_capture_decoder
//
// Watches a multiplexed common-cathode 7-segment display bus and rebuilds
// the 4-digit value it is showing.  A segment/strobe pattern is captured
// once it has been held unchanged for STABLE_CNT cycles with exactly one
// strobe active.  Captures collect in a shadow frame.  When all four digits
// have been captured, the outputs load from the shadow together and
// frame_valid pulses.  A frame that is not completed within FRAME_TIMEOUT
// cycles of its first capture is abandoned, and frame_timeout pulses.
//
// Parameters
//   STABLE_CNT     cycles a pattern must hold before capture (1..15)
//   FRAME_TIMEOUT  cycles allowed to complete a frame (8..65535)
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   seg[6:0]       segment lines, bit6=a .. bit0=g, 1 = lit
//   dig_en[3:0]    digit strobe, one-hot, bit i selects digit i
//   digits[15:0]   decoded frame, digit i at [4i+3:4i]
//   err[3:0]       per digit: last captured pattern was not a known glyph
//   ovf[3:0]       per digit: last captured pattern was the overflow glyph
//   frame_valid    one-cycle pulse when digits/err/ovf update
//   frame_timeout  one-cycle pulse when a partial frame is abandoned
// ---------------------------------------------------------------------------
module seg7_capture_decoder #(
  parameter int STABLE_CNT    = 3,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] digits,
  output logic [3:0]  err,
  output logic [3:0]  ovf,
  output logic        frame_valid,
  output logic        frame_timeout
);

  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CNT);
  localparam logic [15:0] TMO_LAST   = 16'(FRAME_TIMEOUT - 1);

  // Segment patterns, bit6=a .. bit0=g.
  localparam logic [6:0] PAT_0   = 7'b1111110;
  localparam logic [6:0] PAT_1   = 7'b0110000;
  localparam logic [6:0] PAT_2   = 7'b1101101;
  localparam logic [6:0] PAT_3   = 7'b1111001;
  localparam logic [6:0] PAT_4   = 7'b0110011;
  localparam logic [6:0] PAT_5   = 7'b1011011;
  localparam logic [6:0] PAT_6   = 7'b1011111;
  localparam logic [6:0] PAT_7   = 7'b1110000;
  localparam logic [6:0] PAT_8   = 7'b1111111;
  localparam logic [6:0] PAT_9   = 7'b1111011;
  localparam logic [6:0] PAT_OVF = 7'b1110111;

  // ---------------------------------------------------------------------
  // Glyph decode: returns {ovf, err, value[3:0]}.
  // ---------------------------------------------------------------------
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      PAT_0:   r = {2'b00, 4'h0};
      PAT_1:   r = {2'b00, 4'h1};
      PAT_2:   r = {2'b00, 4'h2};
      PAT_3:   r = {2'b00, 4'h3};
      PAT_4:   r = {2'b00, 4'h4};
      PAT_5:   r = {2'b00, 4'h5};
      PAT_6:   r = {2'b00, 4'h6};
      PAT_7:   r = {2'b00, 4'h7};
      PAT_8:   r = {2'b00, 4'h8};
      PAT_9:   r = {2'b00, 4'h9};
      PAT_OVF: r = {2'b10, 4'hA};
      default: r = {2'b01, 4'hF};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Input stage: registered copy of the bus plus a saturating stability
  // counter.
  // ---------------------------------------------------------------------
  logic [6:0] seg_q;
  logic [3:0] en_q;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       en_onehot;
  logic       stable;
  logic       capture;

  // A zero or multi-hot strobe never counts as stable, so a strobe fault
  // simply prevents capture and raises no error flag.
  assign en_onehot = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
  assign stable    = ({seg, dig_en} == {seg_q, en_q}) && en_onehot;

  always_comb begin
    cnt_next = 4'd0;
    if (stable) begin
      cnt_next = (cnt == STABLE_MAX) ? cnt : cnt + 4'd1;
    end
  end

  // Capture fires only on the edge where the counter reaches STABLE_MAX.
  // After that the counter saturates, so one dwell produces one capture.
  assign capture = stable && (cnt == STABLE_MAX - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'd0;
      en_q  <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      seg_q <= seg;
      en_q  <= dig_en;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Frame assembly.
  // ---------------------------------------------------------------------
  logic [15:0] sh_val;
  logic [3:0]  sh_err;
  logic [3:0]  sh_ovf;
  logic [15:0] sh_val_n;
  logic [3:0]  sh_err_n;
  logic [3:0]  sh_ovf_n;
  logic [3:0]  mask;
  logic [3:0]  mask_set;
  logic [15:0] tcnt;
  logic [5:0]  dec;
  logic        frame_done;
  logic        tmo_hit;

  // While capturing, seg equals seg_q, so the registered copy is decoded.
  assign dec = decode_seg(seg_q);

  // Next shadow contents including this edge's capture.  The outputs load
  // from this value so that the digit completing a frame is included.
  always_comb begin
    sh_val_n = sh_val;
    sh_err_n = sh_err;
    sh_ovf_n = sh_ovf;
    for (int i = 0; i < 4; i++) begin
      if (capture && dig_en[i]) begin
        sh_val_n[4*i +: 4] = dec[3:0];
        sh_err_n[i]        = dec[4];
        sh_ovf_n[i]        = dec[5];
      end
    end
  end

  assign mask_set   = mask | dig_en;
  assign frame_done = capture && (mask_set == 4'hF);
  assign tmo_hit    = (mask != 4'd0) && (tcnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val        <= 16'd0;
      sh_err        <= 4'd0;
      sh_ovf        <= 4'd0;
      mask          <= 4'd0;
      tcnt          <= 16'd0;
      digits        <= 16'd0;
      err           <= 4'd0;
      ovf           <= 4'd0;
      frame_valid   <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      frame_valid   <= 1'b0;
      frame_timeout <= 1'b0;
      if (capture) begin
        sh_val <= sh_val_n;
        sh_err <= sh_err_n;
        sh_ovf <= sh_ovf_n;
      end
      if (frame_done) begin
        // Completion wins over a timeout that lands on the same edge.
        digits      <= sh_val_n;
        err         <= sh_err_n;
        ovf         <= sh_ovf_n;
        frame_valid <= 1'b1;
        mask        <= 4'd0;
        tcnt        <= 16'd0;
      end else if (tmo_hit) begin
        // Abandon the partial frame; a non-completing capture on this same
        // edge is dropped with it.  Published outputs are left alone.
        frame_timeout <= 1'b1;
        mask          <= 4'd0;
        tcnt          <= 16'd0;
      end else begin
        if (capture) begin
          mask <= mask_set;
        end
        // Frame age counts from the first capture; idle frames sit at 0.
        if (mask != 4'd0) begin
          tcnt <= tcnt + 16'd1;
        end else begin
          tcnt <= 16'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture_decoder
//
// Drives seg7_capture_decoder with directed dwell sequences and randomized
// pattern/strobe bursts.  A run-length reference model, kept in this file,
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_seg7_capture_decoder;

  localparam int SC = 3;
  localparam int FT = 1024;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] digits;
  logic [3:0]  err;
  logic [3:0]  ovf;
  logic        frame_valid;
  logic        frame_timeout;

  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CNT(SC), .FRAME_TIMEOUT(FT)) dut (
    .clk           (clk),
    .rst           (rst),
    .seg           (seg),
    .dig_en        (dig_en),
    .digits        (digits),
    .err           (err),
    .ovf           (ovf),
    .frame_valid   (frame_valid),
    .frame_timeout (frame_timeout)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};
  localparam logic [6:0] GLYPH_OVF = 7'b1110111;

  // ---------------- reference model state ----------------
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_mask;
  logic [3:0]  m_sval [4];
  logic        m_serr [4];
  logic        m_sovf [4];
  int          m_age;
  logic [15:0] e_digits;
  logic [3:0]  e_err;
  logic [3:0]  e_ovf;
  logic        e_fv;
  logic        e_ft;

  int edge_no        = 0;
  int first_cap_edge = 0;
  int dut_ft_edge    = 0;
  int fv_cnt         = 0;
  int ft_cnt         = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Look the pattern up in the glyph table; anything unknown is an error.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++) begin
      if (glyph[d] == p) return {2'b00, 4'(d)};
    end
    if (p == GLYPH_OVF) return {2'b10, 4'hA};
    return {2'b01, 4'hF};
  endfunction

  task automatic model_reset();
    m_prev   = 11'd0;
    m_run    = 0;
    m_mask   = 4'd0;
    m_age    = 0;
    for (int i = 0; i < 4; i++) begin
      m_sval[i] = 4'd0;
      m_serr[i] = 1'b0;
      m_sovf[i] = 1'b0;
    end
    e_digits = 16'd0;
    e_err    = 4'd0;
    e_ovf    = 4'd0;
    e_fv     = 1'b0;
    e_ft     = 1'b0;
  endtask

  // One clock edge of the model.  m_run counts consecutive identical samples
  // with a one-hot strobe; the (SC+1)-th such sample is the capture edge.
  task automatic model_step(input logic [6:0] s, input logic [3:0] e);
    logic [10:0] smp;
    logic        ok;
    logic        cap;
    logic [5:0]  d;
    int          idx;
    smp = {s, e};
    ok  = $onehot(e);
    if (ok && smp == m_prev) m_run++;
    else if (ok)             m_run = 1;
    else                     m_run = 0;
    m_prev = smp;
    e_fv   = 1'b0;
    e_ft   = 1'b0;
    cap    = (m_run == SC + 1);
    idx    = 0;
    for (int i = 0; i < 4; i++) if (e[i]) idx = i;
    d = ref_decode(s);
    if (m_mask != 4'd0) m_age++;
    if (cap && ((m_mask | e) == 4'hF)) begin
      m_sval[idx] = d[3:0];
      m_serr[idx] = d[4];
      m_sovf[idx] = d[5];
      for (int i = 0; i < 4; i++) begin
        e_digits[4*i +: 4] = m_sval[i];
        e_err[i]           = m_serr[i];
        e_ovf[i]           = m_sovf[i];
      end
      e_fv   = 1'b1;
      m_mask = 4'd0;
    end else if (m_mask != 4'd0 && m_age == FT) begin
      e_ft   = 1'b1;
      m_mask = 4'd0;
    end else if (cap) begin
      m_sval[idx] = d[3:0];
      m_serr[idx] = d[4];
      m_sovf[idx] = d[5];
      if (m_mask == 4'd0) begin
        m_age          = 0;
        first_cap_edge = edge_no;
      end
      m_mask = m_mask | e;
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, "_digits"}, digits, e_digits);
    check({phase, "_err"}, {12'd0, err}, {12'd0, e_err});
    check({phase, "_ovf"}, {12'd0, ovf}, {12'd0, e_ovf});
    check({phase, "_fv"}, {15'd0, frame_valid}, {15'd0, e_fv});
    check({phase, "_ft"}, {15'd0, frame_timeout}, {15'd0, e_ft});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    edge_no++;
    model_step(seg, dig_en);
    #1;
    check_outputs("cyc");
    if (frame_valid) fv_cnt++;
    if (frame_timeout) begin
      ft_cnt++;
      dut_ft_edge = edge_no;
    end
  endtask

  task automatic hold(input logic [6:0] p, input logic [3:0] e, input int n);
    seg    = p;
    dig_en = e;
    repeat (n) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    seg    = 7'd0;
    dig_en = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Straight frame 1,2,3,4 on digits 3..0.
    fv_cnt = 0;
    hold(glyph[1], 4'b1000, 5);
    hold(glyph[2], 4'b0100, 5);
    hold(glyph[3], 4'b0010, 5);
    hold(glyph[4], 4'b0001, 5);
    hold(7'd0, 4'd0, 3);
    check("frame1234_count", 16'(fv_cnt), 16'd1);
    check("frame1234_digits", digits, 16'h1234);
    check("frame1234_flags", {8'd0, err, ovf}, 16'd0);

    // Overflow glyph and blank digit.
    hold(glyph[7], 4'b1000, 5);
    hold(GLYPH_OVF, 4'b0100, 5);
    hold(glyph[7], 4'b0010, 5);
    hold(7'b0000000, 4'b0001, 5);
    hold(7'd0, 4'd0, 2);
    check("ovf_err_digits", digits, 16'h7A7F);
    check("ovf_err_ovf", {12'd0, ovf}, 16'h0004);
    check("ovf_err_err", {12'd0, err}, 16'h0001);

    // Short dwells and bad strobes must not capture anything.
    fv_cnt = 0;
    hold(glyph[5], 4'b0001, 2);
    hold(glyph[6], 4'b0010, 2);
    hold(glyph[8], 4'b0011, 6);
    hold(glyph[9], 4'b0000, 6);
    hold(glyph[1], 4'b1000, 5);
    hold(glyph[1], 4'b0100, 5);
    hold(glyph[1], 4'b0010, 5);
    hold(7'd0, 4'd0, 2);
    check("no_capture_count", 16'(fv_cnt), 16'd0);
    hold(glyph[2], 4'b0001, 5);
    hold(7'd0, 4'd0, 2);
    check("after_short_count", 16'(fv_cnt), 16'd1);
    check("after_short_digits", digits, 16'h1112);

    // Re-capture overwrites the shadow digit.
    hold(glyph[5], 4'b0010, 5);
    hold(glyph[9], 4'b0010, 5);
    hold(glyph[0], 4'b1000, 5);
    hold(glyph[8], 4'b0100, 5);
    hold(glyph[6], 4'b0001, 5);
    hold(7'd0, 4'd0, 2);
    check("recapture_digits", digits, 16'h0896);

    // Partial frame abandoned by the timeout.
    ft_cnt = 0;
    hold(glyph[3], 4'b0001, 5);
    hold(glyph[3], 4'b0010, 5);
    hold(glyph[3], 4'b0100, 5);
    hold(7'd0, 4'd0, 1100);
    check("timeout_count", 16'(ft_cnt), 16'd1);
    check("timeout_latency", 16'(dut_ft_edge - first_cap_edge), 16'd1024);
    check("timeout_keeps_digits", digits, 16'h0896);

    // Randomized bursts of patterns and strobes.
    repeat (300) begin
      logic [6:0] p;
      logic [3:0] e;
      int         r;
      r = $urandom_range(0, 11);
      if (r < 10)       p = glyph[r];
      else if (r == 10) p = GLYPH_OVF;
      else              p = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 8) e = 4'b0001 << $urandom_range(0, 3);
      else                          e = 4'($urandom_range(0, 15));
      hold(p, e, $urandom_range(1, 6));
    end
    hold(7'd0, 4'd0, 3);

    // Asynchronous reset in the middle of a frame.
    hold(glyph[1], 4'b0001, 5);
    hold(glyph[2], 4'b0010, 5);
    hold(glyph[3], 4'b0100, 5);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst = 1'b0;
    fv_cnt = 0;
    hold(glyph[4], 4'b1000, 5);
    hold(7'd0, 4'd0, 2);
    check("post_rst_partial", 16'(fv_cnt), 16'd0);
    hold(glyph[1], 4'b0001, 5);
    hold(glyph[2], 4'b0010, 5);
    hold(glyph[3], 4'b0100, 5);
    hold(7'd0, 4'd0, 2);
    check("post_rst_count", 16'(fv_cnt), 16'd1);
    check("post_rst_digits", digits, 16'h4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
